// File: rtl/aes_pkg.sv
// Shared constants for the AES serial decryption link: width derivation,
// FSM encoding and the default turnaround gap.
package aes_pkg;

  localparam int unsigned NK             = 8;
  localparam int unsigned NB             = 4;
  localparam int unsigned NR             = 14;
  localparam int unsigned GAP_CYCLES_DEF = 2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_KEY  = 3'd1;
  localparam logic [2:0] ST_MSG  = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_READ = 3'd4;
  localparam logic [2:0] ST_FIN  = 3'd5;

  function automatic int unsigned key_bits(input int unsigned nk_words);
    return 32 * nk_words;
  endfunction

  function automatic int unsigned msg_bits(input int unsigned nb_words);
    return 32 * nb_words;
  endfunction

endpackage

// File: rtl/aes_spi_master_shift.sv
// Parameterised shift register: parallel load, shift left (MSB out first)
// with the serial input entering at the LSB.
module spi_shift_reg
  import aes_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_en,
  input  logic         ser_in,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= {q[W-2:0], ser_in};
    end
  end

endmodule

// File: rtl/aes_spi_master.sv
// SPI master for the serial AES decryption unit: sends key then ciphertext,
// waits a turnaround gap, reads the plaintext back. Optional AES_SPI_FRAME_CNT_EN adds frame_cnt.
module aes_spi_master
  import aes_pkg::*;
#(
  parameter int unsigned nk         = NK,
  parameter int unsigned nb         = NB,
  parameter int unsigned nr         = NR,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [32*nk-1:0]  key_in,
  input  logic [32*nb-1:0]  data_in,
  output logic              busy,
  output logic              done,
  output logic [32*nb-1:0]  data_out,
  output logic              mosi,
  input  logic              miso,
  output logic              cs
`ifdef AES_SPI_FRAME_CNT_EN
  ,output logic [15:0]      frame_cnt
`endif
);

  localparam int unsigned key_w = key_bits(nk);
  localparam int unsigned msg_w = msg_bits(nb);
  localparam int unsigned tx_w  = key_w + msg_w;
  localparam int unsigned cnt_w = $clog2(key_w + 1);

  logic [2:0]       state_q, state_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cs_q, cs_d;
  logic [msg_w-1:0] data_out_q, data_out_d;
  logic             tx_load, tx_shift, rx_load, rx_shift;
  logic [tx_w-1:0]  tx_q;
  logic [msg_w-1:0] rx_q;

  // Key and ciphertext go out as one stream; zeros shifted in make mosi idle low.
  spi_shift_reg #(.W(tx_w)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .load     (tx_load),
    .load_val ({key_in, data_in}),
    .shift_en (tx_shift),
    .ser_in   (1'b0),
    .q        (tx_q)
  );

  spi_shift_reg #(.W(msg_w)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .load     (rx_load),
    .load_val ('0),
    .shift_en (rx_shift),
    .ser_in   (miso),
    .q        (rx_q)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cs_d       = cs_q;
    data_out_d = data_out_q;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    rx_load    = 1'b0;
    rx_shift   = 1'b0;
    case (state_q)
      // A start overlapping the done pulse is deliberately dropped.
      ST_IDLE: begin
        if (start && !done_q) begin
          state_d = ST_KEY;
          cnt_d   = '0;
          busy_d  = 1'b1;
          cs_d    = 1'b1;
          tx_load = 1'b1;
          rx_load = 1'b1;
        end
      end
      ST_KEY: begin
        tx_shift = 1'b1;
        if (cnt_q == cnt_w'(key_w - 1)) begin
          state_d = ST_MSG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      ST_MSG: begin
        tx_shift = 1'b1;
        if (cnt_q == cnt_w'(msg_w - 1)) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == cnt_w'(GAP_CYCLES - 1)) begin
          state_d = ST_READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      ST_READ: begin
        rx_shift = 1'b1;
        if (cnt_q == cnt_w'(msg_w - 1)) begin
          state_d = ST_FIN;
          cnt_d   = '0;
          cs_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      ST_FIN: begin
        state_d    = ST_IDLE;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        data_out_d = rx_q;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
        cs_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_q       <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_q       <= cs_d;
      data_out_q <= data_out_d;
    end
  end

`ifdef AES_SPI_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (done_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  // Only the stream MSB drives the pin; nr has no datapath role here.
  logic unused_tx;
  assign unused_tx = ^{tx_q[tx_w-2:0], 32'(nr)};

  assign mosi     = tx_q[tx_w-1];
  assign busy     = busy_q;
  assign done     = done_q;
  assign cs       = cs_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_aes_spi_master.sv
// Directed bench for aes_spi_master with a behavioural SPI slave that records
// mosi and returns a programmed plaintext on miso.
module tb_aes_spi_master;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] key_in;
  logic [127:0] data_in;
  logic         busy;
  logic         done;
  logic [127:0] data_out;
  logic         mosi;
  logic         miso = 1'b0;
  logic         cs;
`ifdef AES_SPI_FRAME_CNT_EN
  logic [15:0]  frame_cnt;
`endif

  always #5 clk = ~clk;

  aes_spi_master dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .data_out (data_out),
    .mosi     (mosi),
    .miso     (miso),
    .cs       (cs)
`ifdef AES_SPI_FRAME_CNT_EN
    ,.frame_cnt (frame_cnt)
`endif
  );

  typedef struct {
    logic [255:0] k;
    logic [127:0] c;
    logic [127:0] p;
  } vec_t;

  vec_t         vecs [3];
  int           cyc = 0;
  int           scnt = 0;
  int           done_cnt = 0;
  logic         cap [0:385];
  logic [127:0] slave_resp = '0;
  int           total = 0;
  int           bad = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // Slave: bit n of the frame is taken on the (n+1)th edge with cs high;
  // result bits are presented so the master samples them from edge 387 on.
  always @(posedge clk) begin
    if (!cs) begin
      scnt <= 0;
      miso <= 1'b0;
    end else begin
      if (scnt < 386) cap[scnt] <= mosi;
      scnt <= scnt + 1;
      if (scnt + 1 >= 386 && scnt + 1 < 514) miso <= slave_resp[513 - (scnt + 1)];
      else miso <= 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic start_frame(input logic [255:0] k, input logic [127:0] c,
                             input logic [127:0] p, output int t0);
    @(negedge clk);
    key_in     = k;
    data_in    = c;
    slave_resp = p;
    start      = 1'b1;
    @(posedge clk);
    #1;
    t0      = cyc;
    start   = 1'b0;
    key_in  = ~k;
    data_in = ~c;
  endtask

  // Returns on the negedge where done is seen; checks latency, result and framing.
  task automatic wait_done(input int t0, input logic [255:0] k, input logic [127:0] c,
                           input logic [127:0] p, input string nm);
    int n = 0;
    int cs_hi = 0;
    int busy_hi = 0;
    logic [255:0] kk;
    logic [127:0] cc;
    do begin
      @(negedge clk);
      n++;
      if (cs) cs_hi++;
      if (busy) busy_hi++;
    end while (!done && n < 600);
    check({nm, " done_seen"}, 256'(done), 256'(1));
    check({nm, " latency"}, 256'(cyc - t0), 256'(515));
    check({nm, " data_out"}, 256'(data_out), 256'(p));
    check({nm, " busy_at_done"}, 256'(busy), 256'(0));
    check({nm, " cs_high_cycles"}, 256'(cs_hi), 256'(514));
    check({nm, " busy_high_cycles"}, 256'(busy_hi), 256'(515));
    for (int i = 0; i < 256; i++) kk[255 - i] = cap[i];
    for (int i = 0; i < 128; i++) cc[127 - i] = cap[256 + i];
    check({nm, " mosi_key"}, kk, k);
    check({nm, " mosi_cipher"}, 256'(cc), 256'(c));
    check({nm, " mosi_gap"}, 256'({cap[384], cap[385]}), 256'(0));
  endtask

  initial begin
    int t0;
    int t1;
    int dc;

    vecs[0].k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    vecs[0].c = 128'h8ea2b7ca516745bfeafc49904b496089;
    vecs[0].p = 128'h00112233445566778899aabbccddeeff;
    vecs[1].k = 256'hffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff;
    vecs[1].c = 128'h0123456789abcdeffedcba9876543210;
    vecs[1].p = 128'hdeadbeef0badf00dcafebabe13579bdf;
    vecs[2].k = {8'h80, 240'h0, 8'h01};
    vecs[2].c = {8'h01, 112'h0, 8'h80};
    vecs[2].p = 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;

    rst     = 1'b1;
    start   = 1'b0;
    key_in  = '0;
    data_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset cs", 256'(cs), 256'(0));
    check("reset busy", 256'(busy), 256'(0));
    check("reset done", 256'(done), 256'(0));
    check("reset mosi", 256'(mosi), 256'(0));
    check("reset data_out", 256'(data_out), 256'(0));

    for (int i = 0; i < 3; i++) begin
      start_frame(vecs[i].k, vecs[i].c, vecs[i].p, t0);
      check($sformatf("vec%0d first_mosi", i), 256'(mosi), 256'(vecs[i].k[255]));
      wait_done(t0, vecs[i].k, vecs[i].c, vecs[i].p, $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d done_pulse", i), 256'(done), 256'(0));
    end

    // Start mid-frame and start overlapping done are both dropped.
    start_frame(vecs[0].k, vecs[0].c, vecs[0].p, t0);
    fork
      wait_done(t0, vecs[0].k, vecs[0].c, vecs[0].p, "ign_a");
      begin
        while (cyc < t0 + 100) @(negedge clk);
        start   = 1'b1;
        key_in  = vecs[2].k;
        data_in = vecs[2].c;
        @(negedge clk);
        start = 1'b0;
      end
    join
    key_in     = vecs[1].k;
    data_in    = vecs[1].c;
    slave_resp = vecs[1].p;
    start      = 1'b1;
    @(negedge clk);
    check("ign done_pulse", 256'(done), 256'(0));
    check("ign start_at_done", 256'(busy), 256'(0));
    @(posedge clk);
    #1;
    t1      = cyc;
    start   = 1'b0;
    key_in  = '0;
    data_in = '0;
    wait_done(t1, vecs[1].k, vecs[1].c, vecs[1].p, "ign_b");
    @(negedge clk);

    // Reset during MSG aborts the frame at once.
    start_frame(vecs[2].k, vecs[2].c, vecs[2].p, t0);
    while (cyc < t0 + 300) @(negedge clk);
    dc = done_cnt;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort cs_async", 256'(cs), 256'(0));
    check("abort busy_async", 256'(busy), 256'(0));
    check("abort mosi_async", 256'(mosi), 256'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort no_done", 256'(done_cnt), 256'(dc));
    check("abort data_out", 256'(data_out), 256'(0));
    check("abort cs_idle", 256'(cs), 256'(0));
    start_frame(vecs[0].k, vecs[0].c, vecs[0].p, t0);
    wait_done(t0, vecs[0].k, vecs[0].c, vecs[0].p, "after_abort");
    @(negedge clk);

`ifdef AES_SPI_FRAME_CNT_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("fcnt reset", 256'(frame_cnt), 256'(0));
    for (int i = 0; i < 3; i++) begin
      start_frame(vecs[i].k, vecs[i].c, vecs[i].p, t0);
      wait_done(t0, vecs[i].k, vecs[i].c, vecs[i].p, $sformatf("fcnt%0d", i));
    end
    check("fcnt three", 256'(frame_cnt), 256'(3));
    @(negedge clk);
    force dut.frame_cnt_q = 16'hffff;
    @(negedge clk);
    release dut.frame_cnt_q;
    start_frame(vecs[1].k, vecs[1].c, vecs[1].p, t0);
    wait_done(t0, vecs[1].k, vecs[1].c, vecs[1].p, "fcnt_wrap");
    check("fcnt wrap", 256'(frame_cnt), 256'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
